// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master, mode 0, MSB first, multi-byte; option macro SPI_MASTER_FLUSH_PULSE_EN
module spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] num_bytes,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    HOLD,
    FLUSH_LO,
    FLUSH_HI
  } state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [2:0]      bit_cnt;
  logic [4:0]      bytes_left;
  logic [7:0]      tx_shreg;
  logic [7:0]      rx_shreg;
  logic            div_end;

  // Each SCLK phase lasts until the down-counter reaches zero.
  assign div_end = (div_cnt == '0);
  assign MOSI    = tx_shreg[7];

  // Transaction sequencer; every output except MOSI is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      bytes_left <= '0;
      tx_shreg   <= '0;
      rx_shreg   <= '0;
      rx_data    <= '0;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      SCLK       <= 1'b0;
      SSEL       <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bytes_left <= (num_bytes == 4'd0) ? 5'd16 : {1'b0, num_bytes};
            busy       <= 1'b1;
            SSEL       <= 1'b1;
            tx_ready   <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          tx_shreg <= tx_data;
          bit_cnt  <= '0;
          div_cnt  <= DIV_LAST;
          state    <= LOW;
        end
        LOW: begin
          if (div_end) begin
            rx_shreg <= {rx_shreg[6:0], MISO};
            div_cnt  <= DIV_LAST;
            SCLK     <= 1'b1;
            state    <= HIGH;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        HIGH: begin
          if (div_end) begin
            SCLK <= 1'b0;
            if (bit_cnt != 3'd7) begin
              bit_cnt  <= bit_cnt + 3'd1;
              tx_shreg <= {tx_shreg[6:0], 1'b0};
              div_cnt  <= DIV_LAST;
              state    <= LOW;
            end else begin
              rx_data    <= rx_shreg;
              rx_valid   <= 1'b1;
              bytes_left <= bytes_left - 5'd1;
              if (bytes_left == 5'd1) begin
                div_cnt <= DIV_LAST;
                state   <= HOLD;
              end else begin
                tx_ready <= 1'b1;
                state    <= LOAD;
              end
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (div_end) begin
            SSEL <= 1'b0;
`ifdef SPI_MASTER_FLUSH_PULSE_EN
            tx_shreg <= '0;
            div_cnt  <= DIV_LAST;
            state    <= FLUSH_LO;
`else
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`endif
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
`ifdef SPI_MASTER_FLUSH_PULSE_EN
        FLUSH_LO: begin
          if (div_end) begin
            SCLK    <= 1'b1;
            div_cnt <= DIV_LAST;
            state   <= FLUSH_HI;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        FLUSH_HI: begin
          if (div_end) begin
            SCLK  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed bench for spi_master at CLK_DIV=2 and CLK_DIV=1
module tb_spi_master;

`ifdef SPI_MASTER_FLUSH_PULSE_EN
  localparam int FL = 1;
`else
  localparam int FL = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start2, start1;
  logic [3:0] nb2, nb1;
  logic [7:0] txd2, txd1;
  logic       txr2, rxv2, busy2, done2, sclk2, ssel2, mosi2, miso2;
  logic       txr1, rxv1, busy1, done1, sclk1, ssel1, mosi1, miso1;
  logic [7:0] rxd2, rxd1;
  logic       loop2, miso_lvl2;

  assign miso2 = loop2 ? mosi2 : miso_lvl2;
  assign miso1 = mosi1;

  logic [7:0] tx_tab1 [0:2] = '{8'h01, 8'h80, 8'hFF};
  logic [1:0] tx_idx1 = 2'd0;
  assign txd1 = (tx_idx1 < 2'd3) ? tx_tab1[tx_idx1] : 8'h00;

  spi_master #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .num_bytes(nb2), .tx_data(txd2),
    .tx_ready(txr2), .rx_data(rxd2), .rx_valid(rxv2), .busy(busy2), .done(done2),
    .SCLK(sclk2), .SSEL(ssel2), .MOSI(mosi2), .MISO(miso2)
  );

  spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .num_bytes(nb1), .tx_data(txd1),
    .tx_ready(txr1), .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1), .done(done1),
    .SCLK(sclk1), .SSEL(ssel1), .MOSI(mosi1), .MISO(miso1)
  );

  // Next byte for the CLK_DIV=1 instance advances after each capture edge.
  always @(posedge clk) if (txr1) tx_idx1 <= tx_idx1 + 2'd1;

  int         rise2 = 0, txr2_n = 0, rxv2_n = 0, done2_n = 0, busy2_n = 0;
  logic       sclk2_q = 1'b0;
  logic       rise_ssel [0:255];
  logic       rise_mosi [0:255];
  logic [7:0] rx_log2 [0:63];

  // Cumulative event log of the CLK_DIV=2 instance, sampled mid-cycle.
  always @(negedge clk) begin
    sclk2_q <= sclk2;
    if (sclk2 && !sclk2_q) begin
      rise_ssel[rise2] <= ssel2;
      rise_mosi[rise2] <= mosi2;
      rise2 <= rise2 + 1;
    end
    if (txr2) txr2_n <= txr2_n + 1;
    if (rxv2) begin
      rx_log2[rxv2_n] <= rxd2;
      rxv2_n <= rxv2_n + 1;
    end
    if (done2) done2_n <= done2_n + 1;
    if (busy2) busy2_n <= busy2_n + 1;
  end

  int         txr1_n = 0, rxv1_n = 0, done1_n = 0, busy1_n = 0, ssel1_n = 0;
  logic [7:0] rx_log1 [0:7];

  // Cumulative event log of the CLK_DIV=1 instance.
  always @(negedge clk) begin
    if (txr1) txr1_n <= txr1_n + 1;
    if (rxv1) begin
      rx_log1[rxv1_n] <= rxd1;
      rxv1_n <= rxv1_n + 1;
    end
    if (done1) done1_n <= done1_n + 1;
    if (busy1) busy1_n <= busy1_n + 1;
    if (ssel1) ssel1_n <= ssel1_n + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input bit use1, input int maxc, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick(1);
      if ((use1 ? done1 : done2) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  int         b_r, b_t, b_v, b_d, b_b, b_s;
  logic [7:0] mb;
  int         nff;
  bit         ok;

  initial begin
    rst = 1'b1; start2 = 1'b0; start1 = 1'b0; nb2 = 4'd0; nb1 = 4'd0;
    txd2 = 8'h00; loop2 = 1'b1; miso_lvl2 = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);

    // Reset while idle
    rst = 1'b1;
    tick(2);
    check("rst_ctl", {25'd0, sclk2, ssel2, mosi2, busy2, done2, txr2, rxv2}, 32'd0);
    check("rst_rxd", {24'd0, rxd2}, 32'd0);
    rst = 1'b0;
    tick(2);

    // One byte 0xA5, loopback, CLK_DIV=2
    b_r = rise2; b_t = txr2_n; b_v = rxv2_n; b_d = done2_n; b_b = busy2_n;
    nb2 = 4'd1; txd2 = 8'hA5; loop2 = 1'b1;
    start2 = 1'b1; tick(1); start2 = 1'b0;
    wait_done(1'b0, 300, "a5_done_seen");
    tick(4);
    check("a5_txr", txr2_n - b_t, 1);
    check("a5_rise", rise2 - b_r, 8 + FL);
    mb = 8'h00;
    for (int k = 0; k < 8; k++) mb = {mb[6:0], rise_mosi[b_r + k]};
    check("a5_mosi", {24'd0, mb}, 32'hA5);
    check("a5_rxv", rxv2_n - b_v, 1);
    check("a5_rxd", {24'd0, rx_log2[b_v]}, 32'hA5);
    check("a5_busy", busy2_n - b_b, 35 + 4 * FL);
    check("a5_done", done2_n - b_d, 1);
    if (FL == 1) begin
      check("flush_ssel", {31'd0, rise_ssel[b_r + 8]}, 32'd0);
      check("flush_mosi", {31'd0, rise_mosi[b_r + 8]}, 32'd0);
    end

    // Three bytes, CLK_DIV=1, new data per tx_ready
    nb1 = 4'd3;
    start1 = 1'b1; tick(1); start1 = 1'b0;
    wait_done(1'b1, 300, "d1_done_seen");
    tick(4);
    check("d1_txr", txr1_n, 3);
    check("d1_rxv", rxv1_n, 3);
    check("d1_rx0", {24'd0, rx_log1[0]}, 32'h01);
    check("d1_rx1", {24'd0, rx_log1[1]}, 32'h80);
    check("d1_rx2", {24'd0, rx_log1[2]}, 32'hFF);
    check("d1_busy", busy1_n, 52 + 2 * FL);
    check("d1_ssel", ssel1_n, 52);
    check("d1_done", done1_n, 1);

    // Sixteen bytes (num_bytes=0), MISO high, stray start mid-transfer
    b_r = rise2; b_t = txr2_n; b_v = rxv2_n; b_d = done2_n; b_b = busy2_n;
    loop2 = 1'b0; miso_lvl2 = 1'b1; nb2 = 4'd0; txd2 = 8'h3C;
    start2 = 1'b1; tick(1); start2 = 1'b0;
    tick(100);
    start2 = 1'b1; tick(1); start2 = 1'b0;
    wait_done(1'b0, 1000, "x16_done_seen");
    tick(20);
    check("x16_txr", txr2_n - b_t, 16);
    check("x16_rxv", rxv2_n - b_v, 16);
    nff = 0;
    for (int k = 0; k < 16; k++) if (rx_log2[b_v + k] == 8'hFF) nff++;
    check("x16_rx_ff", nff, 16);
    check("x16_rise", rise2 - b_r, 128 + FL);
    check("x16_busy", busy2_n - b_b, 530 + 4 * FL);
    check("x16_done", done2_n - b_d, 1);
    check("x16_idle", {31'd0, busy2}, 32'd0);

    // Reset after third rising edge aborts the transfer
    b_r = rise2; b_v = rxv2_n; b_d = done2_n;
    loop2 = 1'b1; nb2 = 4'd1; txd2 = 8'h5A;
    start2 = 1'b1; tick(1); start2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (rise2 - b_r >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_rise3", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    tick(1);
    check("abort_ctl", {27'd0, sclk2, ssel2, busy2, rxv2, done2}, 32'd0);
    check("abort_rxd", {24'd0, rxd2}, 32'd0);
    rst = 1'b0;
    tick(60);
    check("abort_rxv", rxv2_n - b_v, 0);
    check("abort_done", done2_n - b_d, 0);

    // Normal transaction after the abort
    b_t = txr2_n; b_v = rxv2_n; b_d = done2_n;
    start2 = 1'b1; tick(1); start2 = 1'b0;
    wait_done(1'b0, 300, "re_done_seen");
    tick(4);
    check("re_txr", txr2_n - b_t, 1);
    check("re_rxv", rxv2_n - b_v, 1);
    check("re_rxd", {24'd0, rx_log2[b_v]}, 32'h5A);
    check("re_done", done2_n - b_d, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI controller that drives the other end of the demoscene's SPI peripheral: generates SCLK, SSEL, MOSI and samples MISO.
- Runs multi-byte transactions, MSB first, SCLK idle low. Data is launched on the SCLK falling edge and sampled by the peripheral on the rising edge.
- SSEL is active-high (selected = 1), matching the peripheral.
- Sits between on-chip control logic (byte source/sink) and the SPI pins.

Parameters:
- CLK_DIV, 2: SCLK half-period in clk cycles; legal range >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- num_bytes  in  4  bytes per transaction, sampled at start; 0 means 16
- tx_data  in  8  next byte to send; sampled on the clock edge that ends a tx_ready cycle
- tx_ready  out  1  one-cycle pulse; tx_data is captured this cycle
- rx_data  out  8  last received byte; holds until the next byte completes
- rx_valid  out  1  one-cycle pulse; rx_data is updated
- busy  out  1  high from LOAD through end of transaction
- done  out  1  one-cycle pulse on return to IDLE after a completed transaction
- SCLK  out  1  SPI clock
- SSEL  out  1  SPI select, active-high
- MOSI  out  1  SPI data out, equal to tx shift register bit 7
- MISO  in  1  SPI data in

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. SCLK, SSEL, MOSI, tx_ready, rx_valid, done, busy all 0. rx_data=0x00. Internal counters and shift registers cleared.
- Reset mid-transaction aborts immediately. Outputs are at reset values the next cycle; no done, no rx_valid.
- State machine, all outputs registered or pure Moore:
  - IDLE: SSEL=0, SCLK=0, busy=0. On start=1, load bytes_left (5-bit; num_bytes, or 16 if 0) and go to LOAD.
  - LOAD (1 cycle): SSEL=1, SCLK=0, busy=1, tx_ready=1. Capture tx_data into tx shift register, clear bit_cnt, go to LOW.
  - LOW (CLK_DIV cycles): SCLK=0. On the final cycle, rx_shreg <= {rx_shreg[6:0], MISO}, then go to HIGH.
  - HIGH (CLK_DIV cycles): SCLK=1. On the final cycle:
    - If bit_cnt<7: bit_cnt++, tx shift left by 1 (MOSI updates as SCLK falls), go to LOW.
    - If bit_cnt==7: rx_data <= completed byte, rx_valid=1 next cycle, bytes_left--. If bytes_left was 1, go to HOLD; else go to LOAD.
  - HOLD (CLK_DIV cycles): SSEL=1, SCLK=0, then go to IDLE. done=1 in the first IDLE cycle.
- SSEL setup before the first rising edge is 1+CLK_DIV cycles. Inter-byte SCLK low time is CLK_DIV+1 cycles.
- Total busy cycles per transaction: N*(1+16*CLK_DIV) + CLK_DIV.
- start while busy is ignored. start in the done cycle (IDLE) is accepted.
- MISO is sampled exactly once per bit. The peripheral's response appears shifted by its own register stage; no compensation here.
- The division counter is ceil(log2(CLK_DIV+1)) bits and wraps only through an explicit reload.

Optional Feature:
- Macro SPI_MASTER_FLUSH_PULSE_EN.
- When defined: after HOLD, enter FLUSH. SSEL=0, MOSI=0, SCLK=0 for CLK_DIV cycles, then SCLK=1 for CLK_DIV cycles, then IDLE.
  - This is one SCLK edge with select deasserted, so the peripheral clears its bit/byte counters.
  - busy stays 1 through FLUSH. done is asserted in the first IDLE cycle after FLUSH.
  - Busy cycles increase by 2*CLK_DIV.
- When undefined: HOLD goes directly to IDLE; SCLK never toggles while SSEL=0.

Test Plan:
- Reset: assert rst 2 cycles mid-idle -> SCLK=SSEL=MOSI=busy=done=tx_ready=rx_valid=0, rx_data=0x00.
- CLK_DIV=2, num_bytes=1, tx_data=0xA5, MISO tied to MOSI -> 1 tx_ready, 8 SCLK rising edges, MOSI bits 1,0,1,0,0,1,0,1, rx_valid once with rx_data=0xA5, busy for 35 cycles, done once.
- CLK_DIV=1, num_bytes=3, tx_data 0x01,0x80,0xFF supplied on successive tx_ready pulses, loopback -> 3 tx_ready, 3 rx_valid with 0x01,0x80,0xFF, SSEL continuously high, 1 done.
- num_bytes=0, MISO held 1 -> 16 tx_ready, 16 rx_valid each 0xFF, 128 rising edges; start pulsed mid-transfer is ignored.
- rst pulsed after the 3rd SCLK rising edge -> next cycle SSEL=0, SCLK=0, busy=0, no rx_valid, no done; a new start then runs normally.
- With SPI_MASTER_FLUSH_PULSE_EN, num_bytes=1 -> exactly 9 SCLK rising edges, the 9th with SSEL=0 and MOSI=0; done after it.
